// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a valid/ready handshake, a stored carry flag
// for chained ADC/SBB, and an iterative shift-add multiplier.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    operation handshake (in_ready is combinational)
//   a, b, opcode         operands and operation select
//   out_valid/out_ready  result handshake
//   result, s,c,p,z,v    registered result and flags
//   busy                 multiply in progress
module alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             s,
  output logic             c,
  output logic             p,
  output logic             z,
  output logic             v,
  output logic             busy
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned W1  = WIDTH + 1;
  localparam int unsigned W2  = 2 * WIDTH;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_INC  = 4'd2,  OP_DEC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR  = 4'd6,  OP_NOT = 4'd7;
  localparam logic [3:0] OP_ADC = 4'd8,  OP_SBB = 4'd9,  OP_SHL  = 4'd10, OP_SHR = 4'd11;
  localparam logic [3:0] OP_SAR = 4'd12, OP_CMP = 4'd13, OP_MUL  = 4'd14, OP_PASSB = 4'd15;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state;
  logic             cf;
  logic [SHW-1:0]   cnt;
  logic [W2-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [W2-1:0]    acc;

  logic [WIDTH-1:0] arith_b;
  logic             arith_ci;
  logic [W1-1:0]    sum, dif, shl_t, shr_t, sar_t;
  logic [SHW-1:0]   shamt;
  logic             add_v, sub_v;
  logic [WIDTH-1:0] alu_r, flag_src;
  logic             alu_c, alu_v;
  logic [W2-1:0]    acc_nxt;
  logic [WIDTH-1:0] mul_r;
  logic             mul_c;
  logic             accept;

  assign in_ready = rst_n && !busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle datapath; all arithmetic at WIDTH+1 so bit WIDTH is carry/borrow.
  always_comb begin
    arith_b  = b;
    arith_ci = 1'b0;
    case (opcode)
      OP_INC, OP_DEC: arith_b  = WIDTH'(1);
      OP_ADC, OP_SBB: arith_ci = cf;
      default: ;
    endcase
    sum   = W1'(a) + W1'(arith_b) + W1'(arith_ci);
    dif   = W1'(a) - W1'(arith_b) - W1'(arith_ci);
    add_v = (a[WIDTH-1] == arith_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    sub_v = (a[WIDTH-1] != arith_b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
    shamt = b[SHW-1:0];
    // Extra guard bit catches the last bit shifted out; zero for shamt==0.
    shl_t = W1'(a) << shamt;
    shr_t = {a, 1'b0} >> shamt;
    sar_t = $signed({a, 1'b0}) >>> shamt;

    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (opcode)
      OP_ADD, OP_INC, OP_ADC: begin alu_r = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; alu_v = add_v; end
      OP_SUB, OP_DEC, OP_SBB: begin alu_r = dif[WIDTH-1:0]; alu_c = dif[WIDTH]; alu_v = sub_v; end
      OP_CMP:   begin alu_r = a; alu_c = dif[WIDTH]; alu_v = sub_v; end
      OP_AND:   alu_r = a & b;
      OP_OR:    alu_r = a | b;
      OP_XOR:   alu_r = a ^ b;
      OP_NOT:   alu_r = ~a;
      OP_SHL:   begin alu_r = shl_t[WIDTH-1:0]; alu_c = shl_t[WIDTH]; end
      OP_SHR:   begin alu_r = shr_t[WIDTH:1];   alu_c = shr_t[0]; end
      OP_SAR:   begin alu_r = sar_t[WIDTH:1];   alu_c = sar_t[0]; end
      OP_PASSB: alu_r = b;
      default: ;
    endcase
    // CMP keeps a in result but reports sign/zero/parity of a-b.
    flag_src = (opcode == OP_CMP) ? dif[WIDTH-1:0] : alu_r;
  end

  // One shift-add step; the last step's sum is the full product.
  always_comb begin
    acc_nxt = acc + (mplier[0] ? mcand : '0);
    mul_r   = acc_nxt[WIDTH-1:0];
    mul_c   = |acc_nxt[W2-1:WIDTH];
  end

  // Control FSM, output register and multiplier state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      cnt       <= '0;
      cf        <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      s         <= 1'b0;
      c         <= 1'b0;
      p         <= 1'b0;
      z         <= 1'b0;
      v         <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (opcode == OP_MUL) begin
              state  <= S_MUL;
              busy   <= 1'b1;
              cnt    <= '0;
              mcand  <= W2'(a);
              mplier <= b;
              acc    <= '0;
            end else begin
              out_valid <= 1'b1;
              result    <= alu_r;
              s         <= flag_src[WIDTH-1];
              c         <= alu_c;
              p         <= ~^flag_src;
              z         <= (flag_src == '0);
              v         <= alu_v;
              cf        <= alu_c;
            end
          end
        end
        S_MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == SHW'(WIDTH - 1)) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b1;
            result    <= mul_r;
            s         <= mul_r[WIDTH-1];
            c         <= mul_c;
            p         <= ~^mul_r;
            z         <= (mul_r == '0);
            v         <= mul_c;
            cf        <= mul_c;
          end else begin
            cnt <= cnt + SHW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
